// File: rtl/serial_receiver_if.sv
// Handshake bundle between the serial receiver and the logic that drives
// its line and consumes its bytes. DEPTH must match the receiver instance.
interface serial_receiver_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx;         // idle-high serial line
    logic          rd;         // pop strobe
    logic [7:0]    byte_out;   // FIFO head, 8'h00 when empty
    logic          valid;      // FIFO not empty
    logic [CW-1:0] count;      // FIFO occupancy
    logic          busy;       // frame in progress
    logic          frame_err;  // one-cycle pulse on a bad stop bit
    logic          overrun;    // one-cycle pulse on a dropped good byte

    modport master (
        output rx, rd,
        input  byte_out, valid, count, busy, frame_err, overrun
    );

    modport slave (
        input  rx, rd,
        output byte_out, valid, count, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_receiver.sv
// Single-clock deserialiser: start bit, 8 data bits LSB first, stop bit,
// one bit per clock. Good bytes land in a show-ahead FIFO of DEPTH entries
// (power of two, >= 2). HUNT waits for an idle line so that a reset released
// mid-frame cannot be mistaken for a start bit.
module serial_receiver #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    serial_receiver_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        HUNT,
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;
    logic          overrun_q;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          full;
    logic          not_empty;
    logic          pop;
    logic          good_byte;
    logic          push;

    // Push/pop qualification and next occupancy, decoded from registers and the strobes.
    // NOTE: every signal gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        not_empty = (count_q != '0);
        pop       = bus.rd && not_empty;
        good_byte = (state_q == STOP) && bus.rx;
        push      = good_byte && (!full || pop);
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Frame FSM with registered error/overrun pulses.
    // NOTE: state uses non-blocking assignments so every branch reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (bus.rx) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!bus.rx) begin
                        state_q   <= DATA;
                        bit_cnt_q <= 3'd0;
                    end
                end
                DATA: begin
                    shift_q[bit_cnt_q] <= bus.rx;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                STOP: begin
                    if (bus.rx) begin
                        overrun_q <= !push;
                        state_q   <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage write.
    // NOTE: storage has no reset; byte_out is forced to 8'h00 while empty, so stale contents never reach the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.valid     = not_empty;
    assign bus.count     = count_q;
    assign bus.byte_out  = not_empty ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.busy      = (state_q == DATA) || (state_q == STOP);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point, away from the edge.
module tb_serial_receiver;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    serial_receiver_if #(.DEPTH(DEPTH)) bus ();

    serial_receiver #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, then the stop bit; optional rd on the stop edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_at_stop);
        bus.rx = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick();
        end
        bus.rx = stop_bit;
        bus.rd = rd_at_stop;
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    initial begin
        logic [7:0] b;

        // Reset values
        reset  = 1'b0;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        #12;
        check("rst_valid", bus.valid, 0);
        check("rst_byte", bus.byte_out, 8'h00);
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // Test 1: single frame 8'h4A with latency checks
        b = 8'h4A;
        check("t1_busy_idle", bus.busy, 0);
        bus.rx = 1'b0;
        tick();
        check("t1_busy_e0", bus.busy, 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_valid_early", bus.valid, 0);
            bus.rx = b[i];
            tick();
        end
        check("t1_valid_e8", bus.valid, 0);
        check("t1_busy_e8", bus.busy, 1);
        bus.rx = 1'b1;
        tick();
        check("t1_valid_e9", bus.valid, 1);
        check("t1_byte", bus.byte_out, 8'h4A);
        check("t1_count", bus.count, 1);
        check("t1_ferr", bus.frame_err, 0);
        check("t1_ovr", bus.overrun, 0);
        check("t1_busy_e9", bus.busy, 0);
        pop();
        check("t1_pop_valid", bus.valid, 0);
        check("t1_pop_byte", bus.byte_out, 8'h00);

        // Test 2: back-to-back frames, then drain
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        check("t2_count", bus.count, 2);
        check("t2_head0", bus.byte_out, 8'h55);
        pop();
        check("t2_head1", bus.byte_out, 8'hA3);
        check("t2_count1", bus.count, 1);
        pop();
        check("t2_empty_byte", bus.byte_out, 8'h00);
        check("t2_empty_valid", bus.valid, 0);
        check("t2_empty_count", bus.count, 0);

        // Test 3: bad stop bit, line held low, then recovery
        send_frame(8'hFF, 1'b0, 1'b0);
        check("t3_ferr_pulse", bus.frame_err, 1);
        check("t3_no_push", bus.count, 0);
        check("t3_busy", bus.busy, 0);
        tick();
        check("t3_ferr_low", bus.frame_err, 0);
        repeat (4) tick();
        check("t3_hunt_busy", bus.busy, 0);
        bus.rx = 1'b1;
        tick();
        send_frame(8'h3C, 1'b1, 1'b0);
        check("t3_byte", bus.byte_out, 8'h3C);
        check("t3_count", bus.count, 1);
        check("t3_ferr_good", bus.frame_err, 0);
        pop();

        // Test 4a: overrun on the fifth frame
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("t4a_full", bus.count, 4);
        check("t4a_ovr_none", bus.overrun, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("t4a_count", bus.count, 4);
        check("t4a_ovr_pulse", bus.overrun, 1);
        tick();
        check("t4a_ovr_low", bus.overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            check("t4a_drain", bus.byte_out, 32'(i));
            pop();
        end
        check("t4a_empty", bus.valid, 0);

        // Test 4b: pop on the fifth frame's stop edge lets it in
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("t4b_ovr", bus.overrun, 0);
        check("t4b_count", bus.count, 4);
        for (int i = 2; i <= 5; i++) begin
            check("t4b_drain", bus.byte_out, 32'(i));
            pop();
        end
        check("t4b_empty", bus.count, 0);

        // Test 5: asynchronous reset at D3, remaining zero bits ignored
        send_frame(8'h81, 1'b1, 1'b0);
        check("t5_pre_count", bus.count, 1);
        bus.rx = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.rx = 1'b0;
            tick();
        end
        bus.rx = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("t5_async_valid", bus.valid, 0);
        check("t5_async_count", bus.count, 0);
        check("t5_async_byte", bus.byte_out, 8'h00);
        check("t5_async_busy", bus.busy, 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("t5_hunt_busy", bus.busy, 0);
        check("t5_hunt_valid", bus.valid, 0);
        check("t5_hunt_ferr", bus.frame_err, 0);
        bus.rx = 1'b1;
        tick();
        check("t5_stop_ferr", bus.frame_err, 0);
        check("t5_stop_count", bus.count, 0);
        send_frame(8'h96, 1'b1, 1'b0);
        check("t5_byte", bus.byte_out, 8'h96);
        check("t5_count", bus.count, 1);
        pop();

        // Test 6: pop while empty, then push with a coincident empty pop
        bus.rd = 1'b1;
        tick();
        tick();
        bus.rd = 1'b0;
        check("t6_count", bus.count, 0);
        check("t6_valid", bus.valid, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("t6_byte", bus.byte_out, 8'h5A);
        check("t6_count1", bus.count, 1);
        pop();
        check("t6_drained", bus.count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
